// File: rtl/ps2_cmd_sequencer.sv
// Host-side PS/2 command sequencer: keyboard reset at power-up and LED updates,
// driving the open-drain clock/data lines and handling ACK, RESEND, timeouts and retries.
module ps2_cmd_sequencer #(
  parameter int unsigned INHIBIT_CYC = 2400,
  parameter int unsigned TIMEOUT_CYC = 480000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       busy,
  output logic       init_done,
  output logic       error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW = $clog2(MAX_RETRY + 1);

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_LED     = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_START, ST_TXBITS, ST_ACK, ST_WAIT_RESP, ST_WAIT_BAT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [AW-1:0] attempt_q, attempt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [10:0]   sh_q, sh_d;
  logic          seq_init_q, seq_init_d;
  logic          step_q, step_d;
  logic [7:0]    led_byte_q, led_byte_d;
  logic          init_pend_q, init_pend_d;
  logic          led_pend_q, led_pend_d;
  logic          led_seen_q, led_seen_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;
  logic          error_q, error_d;

  logic [2:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          fall_edge;
  logic          dat_line;
  logic          timed_out;
  logic          fail;
  logic          done;
  logic [7:0]    cur_byte;

  // Two-flop synchronizers plus one delay flop on the clock for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
    end
  end

  assign fall_edge = clk_sync_q[2] & ~clk_sync_q[1];
  assign dat_line  = dat_sync_q[1];
  assign timed_out = (tmr_q == TW'(TIMEOUT_CYC - 1));
  assign cur_byte  = seq_init_q ? CMD_RESET : (step_q ? led_byte_q : CMD_LED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      attempt_q   <= '0;
      bitcnt_q    <= '0;
      sh_q        <= '1;
      seq_init_q  <= 1'b0;
      step_q      <= 1'b0;
      led_byte_q  <= '0;
      init_pend_q <= 1'b1;
      led_pend_q  <= 1'b0;
      led_seen_q  <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      attempt_q   <= attempt_d;
      bitcnt_q    <= bitcnt_d;
      sh_q        <= sh_d;
      seq_init_q  <= seq_init_d;
      step_q      <= step_d;
      led_byte_q  <= led_byte_d;
      init_pend_q <= init_pend_d;
      led_pend_q  <= led_pend_d;
      led_seen_q  <= led_seen_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + TW'(1);
    attempt_d   = attempt_q;
    bitcnt_d    = bitcnt_q;
    sh_d        = sh_q;
    seq_init_d  = seq_init_q;
    step_d      = step_q;
    led_byte_d  = led_byte_q;
    init_pend_d = init_pend_q;
    led_pend_d  = led_pend_q | led_req;
    led_seen_d  = led_seen_q | (led_req & seq_init_q & (state_q != ST_IDLE));
    init_done_d = init_done_q;
    error_d     = 1'b0;
    fail        = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (init_pend_q) begin
          init_pend_d = 1'b0;
          seq_init_d  = 1'b1;
          step_d      = 1'b0;
          attempt_d   = '0;
          led_seen_d  = 1'b0;
          state_d     = ST_INHIBIT;
        end else if (led_pend_q) begin
          led_pend_d  = led_req;
          seq_init_d  = 1'b0;
          step_d      = 1'b0;
          attempt_d   = '0;
          state_d     = ST_INHIBIT;
        end
      end
      // Clock held low INHIBIT_CYC cycles in total; the last one overlaps the start bit
      ST_INHIBIT: begin
        if (tmr_q == TW'(INHIBIT_CYC - 2)) begin
          sh_d     = {1'b1, ~^cur_byte, cur_byte, 1'b0};
          bitcnt_d = '0;
          state_d  = ST_START;
        end
      end
      ST_START: state_d = ST_TXBITS;
      ST_TXBITS: begin
        if (timed_out) begin
          fail = 1'b1;
        end else if (fall_edge) begin
          sh_d     = {1'b1, sh_q[10:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (timed_out) begin
          fail = 1'b1;
        end else if (fall_edge) begin
          if (!dat_line) state_d = ST_WAIT_RESP;
          else           fail    = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (timed_out) begin
          fail = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == RSP_ACK) begin
            if (seq_init_q) begin
              state_d = ST_WAIT_BAT;
            end else if (!step_q) begin
              step_d     = 1'b1;
              led_byte_d = {5'b0, led_val};
              attempt_d  = '0;
              state_d    = ST_INHIBIT;
            end else begin
              done = 1'b1;
            end
          end else if (rx_data == RSP_RESEND) begin
            fail = 1'b1;
          end
        end
      end
      ST_WAIT_BAT: begin
        if (timed_out) begin
          fail = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == RSP_BAT_OK) begin
            init_done_d = 1'b1;
            done        = 1'b1;
          end else if (rx_data == RSP_BAT_ERR) begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      if (attempt_q == AW'(MAX_RETRY - 1)) begin
        error_d = 1'b1;
        done    = 1'b1;
      end else begin
        attempt_d = attempt_q + AW'(1);
        state_d   = ST_INHIBIT;
      end
    end

    // A finished or aborted init swallows LED requests that predate it
    if (done) begin
      state_d = ST_IDLE;
      if (seq_init_q && !led_seen_d) led_pend_d = 1'b0;
    end

    if ((state_d != state_q) || (state_d == ST_IDLE)) tmr_d = '0;

    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_START);
    dat_oe_d = ((state_d == ST_START) || (state_d == ST_TXBITS)) && !sh_d[0];
    busy_d   = (state_d != ST_IDLE);
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign init_done  = init_done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: a small PS/2 device model clocks frames
// out of the host and answers with scripted response bytes.
module tb_ps2_cmd_sequencer;

  localparam int unsigned INH = 40;
  localparam int unsigned TMO = 3000;
  localparam int unsigned RETRY = 3;
  localparam int BUDGET = 12000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       busy, init_done, error;

  int n_checks = 0;
  int n_fail = 0;

  int cyc = 0, rise_cnt = 0, err_cnt = 0, last_rise = 0, prev_rise = 0;
  logic oe_prev = 1'b0;

  assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

  ps2_cmd_sequencer #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(RETRY)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .rx_valid(rx_valid), .rx_data(rx_data),
    .led_req(led_req), .led_val(led_val), .busy(busy), .init_done(init_done), .error(error)
  );

  always #5 clk = ~clk;

  // Event monitor: clock-inhibit starts and error-pulse cycles
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (error === 1'b1) err_cnt = err_cnt + 1;
    if (ps2_clk_oe === 1'b1 && oe_prev !== 1'b1) begin
      rise_cnt  = rise_cnt + 1;
      prev_rise = last_rise;
      last_rise = cyc;
    end
    oe_prev = ps2_clk_oe;
  end

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic pulse_led();
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
  endtask

  // Device side of one host->device frame; returns the bits seen on the wire
  task automatic dev_frame(output logic [7:0] b, output logic par, output logic stp,
                           output int inh, output bit ok);
    int t;
    logic bitv;
    ok = 1'b1; b = 8'h00; par = 1'b0; stp = 1'b0; inh = 0; t = 0;
    while (ps2_clk_oe !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
    if (t >= BUDGET) begin ok = 1'b0; return; end
    while (ps2_clk_oe === 1'b1 && inh < BUDGET) begin inh++; @(negedge clk); end
    if (ps2_dat_oe !== 1'b1) ok = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      bitv = ps2_dat_in;
      dev_clk = 1'b1;
      repeat (10) @(negedge clk);
      if (k < 8) b[k] = bitv;
      else if (k == 8) par = bitv;
      else stp = bitv;
    end
    dev_dat = 1'b0;
    repeat (4) @(negedge clk);
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b1;
    repeat (4) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    if (ps2_clk_oe !== 1'b0) begin $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); n_fail++; end
    n_checks++;
    if (ps2_dat_oe !== 1'b0) begin $display("FAIL reset_dat_oe got %b want 0", ps2_dat_oe); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
    n_checks++;
    if (init_done !== 1'b0) begin $display("FAIL reset_init_done got %b want 0", init_done); n_fail++; end
    n_checks++;
    if (error !== 1'b0) begin $display("FAIL reset_error got %b want 0", error); n_fail++; end
    n_checks++;
  endtask

  // Release reset and run the FF / FA / AA init handshake
  task automatic run_init(input string tag);
    logic [7:0] b; logic par, stp; int inh; bit ok;
    reset_n = 1'b1;
    dev_frame(b, par, stp, inh, ok);
    if (!ok || b !== 8'hFF) begin $display("FAIL %s_byte got %h ok %0d want ff", tag, b, ok); n_fail++; end
    n_checks++;
    if ({par, stp} !== 2'b11) begin $display("FAIL %s_par_stop got %b want 11", tag, {par, stp}); n_fail++; end
    n_checks++;
    if (inh != INH) begin $display("FAIL %s_inhibit got %0d want %0d", tag, inh, INH); n_fail++; end
    n_checks++;
    send_rx(8'hFA);
    repeat (100) @(negedge clk);
    if ({busy, init_done} !== 2'b10) begin $display("FAIL %s_wait_bat got %b want 10", tag, {busy, init_done}); n_fail++; end
    n_checks++;
    send_rx(8'hAA);
    @(negedge clk);
    if ({busy, init_done} !== 2'b01) begin $display("FAIL %s_done got %b want 01", tag, {busy, init_done}); n_fail++; end
    n_checks++;
  endtask

  task automatic test_init();
    run_init("init");
  endtask

  task automatic test_led();
    logic [7:0] b; logic par, stp; int inh; bit ok; int r0, e0;
    e0 = err_cnt;
    led_val = 3'b100;
    pulse_led();
    dev_frame(b, par, stp, inh, ok);
    if (!ok || {b, par, stp} !== {8'hED, 2'b11}) begin $display("FAIL led_ed got %h/%b want ed/11", b, {par, stp}); n_fail++; end
    n_checks++;
    if (inh != INH) begin $display("FAIL led_ed_inhibit got %0d want %0d", inh, INH); n_fail++; end
    n_checks++;
    r0 = rise_cnt;
    send_rx(8'h55);
    repeat (20) @(negedge clk);
    if (busy !== 1'b1 || rise_cnt != r0) begin $display("FAIL led_ignore got busy %b rises %0d want 1 %0d", busy, rise_cnt, r0); n_fail++; end
    n_checks++;
    send_rx(8'hFA);
    dev_frame(b, par, stp, inh, ok);
    if (!ok || {b, par, stp} !== {8'h04, 2'b01}) begin $display("FAIL led_val got %h/%b want 04/01", b, {par, stp}); n_fail++; end
    n_checks++;
    if (inh != INH) begin $display("FAIL led_val_inhibit got %0d want %0d", inh, INH); n_fail++; end
    n_checks++;
    send_rx(8'hFA);
    @(negedge clk);
    if (busy !== 1'b0 || err_cnt != e0) begin $display("FAIL led_end got busy %b errs %0d want 0 %0d", busy, err_cnt, e0); n_fail++; end
    n_checks++;
  endtask

  task automatic test_resend();
    logic [7:0] b; logic par, stp; int inh; bit ok; int e0;
    e0 = err_cnt;
    pulse_led();
    dev_frame(b, par, stp, inh, ok);
    if (!ok || b !== 8'hED) begin $display("FAIL resend_first got %h want ed", b); n_fail++; end
    n_checks++;
    send_rx(8'hFE);
    dev_frame(b, par, stp, inh, ok);
    if (!ok || {b, par} !== {8'hED, 1'b1}) begin $display("FAIL resend_again got %h/%b want ed/1", b, par); n_fail++; end
    n_checks++;
    send_rx(8'hFA);
    dev_frame(b, par, stp, inh, ok);
    if (!ok || b !== 8'h04) begin $display("FAIL resend_val got %h want 04", b); n_fail++; end
    n_checks++;
    send_rx(8'hFA);
    @(negedge clk);
    if (busy !== 1'b0 || err_cnt != e0) begin $display("FAIL resend_end got busy %b errs %0d want 0 %0d", busy, err_cnt, e0); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    int t, r0;
    pulse_led();
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
    while (ps2_clk_oe !== 1'b0 && t < BUDGET) begin @(negedge clk); t++; end
    if (t >= BUDGET) begin $display("FAIL midrst_reach_tx got timeout want txbits"); n_fail++; end
    n_checks++;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dev_clk = 1'b0; repeat (10) @(negedge clk);
      dev_clk = 1'b1; repeat (10) @(negedge clk);
    end
    if (ps2_dat_oe !== 1'b1) begin $display("FAIL midrst_d1 got %b want 1", ps2_dat_oe); n_fail++; end
    n_checks++;
    pulse_led();
    #2 reset_n = 1'b0;
    #1;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin $display("FAIL midrst_async got %b want 000", {ps2_clk_oe, ps2_dat_oe, busy}); n_fail++; end
    n_checks++;
    repeat (3) @(negedge clk);
    run_init("midrst_init");
    r0 = rise_cnt;
    repeat (300) @(negedge clk);
    if (rise_cnt != r0) begin $display("FAIL midrst_dropped got %0d rises want 0", rise_cnt - r0); n_fail++; end
    n_checks++;
  endtask

  task automatic test_coalesce();
    logic [7:0] b; logic par, stp; int inh; bit ok; int r0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    dev_frame(b, par, stp, inh, ok);
    if (!ok || b !== 8'hFF) begin $display("FAIL coal_init got %h want ff", b); n_fail++; end
    n_checks++;
    led_val = 3'b001; pulse_led(); repeat (5) @(negedge clk);
    led_val = 3'b010; pulse_led(); repeat (5) @(negedge clk);
    send_rx(8'hFA);
    repeat (20) @(negedge clk);
    led_val = 3'b011; pulse_led(); repeat (5) @(negedge clk);
    send_rx(8'hAA);
    r0 = rise_cnt;
    dev_frame(b, par, stp, inh, ok);
    if (!ok || b !== 8'hED) begin $display("FAIL coal_ed got %h want ed", b); n_fail++; end
    n_checks++;
    send_rx(8'hFA);
    dev_frame(b, par, stp, inh, ok);
    if (!ok || {b, par} !== {8'h03, 1'b1}) begin $display("FAIL coal_val got %h/%b want 03/1", b, par); n_fail++; end
    n_checks++;
    send_rx(8'hFA);
    repeat (300) @(negedge clk);
    if (rise_cnt - r0 != 2) begin $display("FAIL coal_count got %0d inhibits want 2", rise_cnt - r0); n_fail++; end
    n_checks++;
    if ({busy, init_done} !== 2'b01) begin $display("FAIL coal_end got %b want 01", {busy, init_done}); n_fail++; end
    n_checks++;
  endtask

  task automatic test_no_ack();
    int t, r0, e0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    r0 = rise_cnt; e0 = err_cnt;
    reset_n = 1'b1;
    t = 0;
    while (busy !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    while (busy !== 1'b0 && t < BUDGET) begin @(negedge clk); t++; end
    if (t >= BUDGET) begin $display("FAIL noack_busy_fall got timeout want busy 0"); n_fail++; end
    n_checks++;
    if (rise_cnt - r0 != 3) begin $display("FAIL noack_attempts got %0d want 3", rise_cnt - r0); n_fail++; end
    n_checks++;
    if (last_rise - prev_rise != int'(INH + TMO)) begin $display("FAIL noack_attempt_len got %0d want %0d", last_rise - prev_rise, INH + TMO); n_fail++; end
    n_checks++;
    @(negedge clk);
    if (err_cnt - e0 != 1) begin $display("FAIL noack_error got %0d pulses want 1", err_cnt - e0); n_fail++; end
    n_checks++;
    r0 = rise_cnt;
    repeat (300) @(negedge clk);
    if ({busy, init_done, error} !== 3'b000 || rise_cnt != r0) begin
      $display("FAIL noack_idle got %b rises %0d want 000 0", {busy, init_done, error}, rise_cnt - r0); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_led();
    test_resend();
    test_reset_mid();
    test_coalesce();
    test_no_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
